// File: rtl/vid_pixgen.sv
// Pixel-clock video back end: raster timing from shadowed mode registers, FIFO
// word unpacking (MSB pixel first), new-frame restart pulse and underflow latch.
module vid_pixgen #(
  parameter int BUSW = 32,
  parameter int BPP  = 8,
  parameter int LW   = 11
) (
  input  logic            i_pixclk,
  input  logic            i_reset,
  input  logic [LW-1:0]   i_hm_width,
  input  logic [LW-1:0]   i_hm_porch,
  input  logic [LW-1:0]   i_hm_synch,
  input  logic [LW-1:0]   i_hm_raw,
  input  logic [LW-1:0]   i_vm_height,
  input  logic [LW-1:0]   i_vm_porch,
  input  logic [LW-1:0]   i_vm_synch,
  input  logic [LW-1:0]   i_vm_raw,
  output logic            o_rd,
  input  logic            i_valid,
  input  logic [BUSW-1:0] i_word,
  output logic            o_newframe,
  output logic            o_vga_hsync,
  output logic            o_vga_vsync,
  output logic            o_active,
  output logic [BPP-1:0]  o_pixel,
  output logic            o_underflow
);
  localparam int PPW = BUSW / BPP;
  localparam int PW  = (PPW > 1) ? $clog2(PPW) : 1;

  typedef struct packed {
    logic [LW-1:0] len;
    logic [LW-1:0] porch;
    logic [LW-1:0] synch;
    logic [LW-1:0] raw;
  } axis_t;

  axis_t           hm, vm, hm_in, vm_in;
  logic [LW-1:0]   hpos, vpos;
  logic [PW-1:0]   pcnt;
  logic [BUSW-1:0] sreg;
  logic            lost;
  logic            act, need, line_end, frame_end, last_px, nf_cond;

  assign hm_in = {i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw};
  assign vm_in = {i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw};

  assign line_end  = (hpos == hm.raw - LW'(1));
  assign frame_end = line_end && (vpos == vm.raw - LW'(1));
  assign act       = (hpos < hm.len) && (vpos < vm.len);
  assign need      = act && (pcnt == '0);
  assign last_px   = (hpos == hm.len - LW'(1));
  assign nf_cond   = (hpos == '0) && (vpos == vm.len);
  assign o_rd      = need && i_valid && !lost && !i_reset;

  // Mode values are only sampled at frame wrap so a frame never mixes timings.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      hm   <= hm_in;
      vm   <= vm_in;
      hpos <= '0;
      vpos <= i_vm_height;
    end else begin
      if (line_end) begin
        hpos <= '0;
        vpos <= (vpos == vm.raw - LW'(1)) ? '0 : vpos + LW'(1);
      end else begin
        hpos <= hpos + LW'(1);
      end
      if (frame_end) begin
        hm <= hm_in;
        vm <= vm_in;
      end
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      o_vga_hsync <= 1'b1;
      o_vga_vsync <= 1'b1;
      o_active    <= 1'b0;
      o_pixel     <= '0;
      o_newframe  <= 1'b0;
      o_underflow <= 1'b0;
      pcnt        <= '0;
      lost        <= 1'b0;
      sreg        <= '0;
    end else begin
      o_vga_hsync <= !((hpos >= hm.porch) && (hpos < hm.synch));
      o_vga_vsync <= !((vpos >= vm.porch) && (vpos < vm.synch));
      o_active    <= act;
      o_newframe  <= nf_cond;
      o_underflow <= need && !i_valid && !lost;

      // Restarting pcnt at line end drops any unused pixels of a partial word.
      if (act)
        pcnt <= (last_px || pcnt == PW'(PPW - 1)) ? '0 : pcnt + PW'(1);
      else
        pcnt <= '0;

      if (!act) begin
        o_pixel <= '0;
      end else if (need) begin
        if (i_valid && !lost) begin
          o_pixel <= i_word[BUSW-1 -: BPP];
          sreg    <= i_word << BPP;
        end else begin
          o_pixel <= '0;
        end
      end else begin
        o_pixel <= lost ? '0 : sreg[BUSW-1 -: BPP];
        sreg    <= sreg << BPP;
      end

      // Once a word is missed the line alignment is gone; only a FIFO restart recovers it.
      if (nf_cond)
        lost <= 1'b0;
      else if (need && !i_valid)
        lost <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vid_pixgen.sv
// Randomized scoreboard bench for vid_pixgen: a raster-index reference model
// predicts every cycle's o_rd and registered outputs, a monitor compares them.
module tb_vid_pixgen;
  localparam int BUSW = 32;
  localparam int BPP  = 8;
  localparam int LW   = 11;
  localparam int PPW  = BUSW / BPP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [LW-1:0]   hw, hp, hs, hr, vh, vp, vs, vr;
  logic            valid = 1'b0;
  logic [BUSW-1:0] word = '0;
  logic            rd, nf, hsync, vsync, active, uflow;
  logic [BPP-1:0]  pixel;

  vid_pixgen #(.BUSW(BUSW), .BPP(BPP), .LW(LW)) dut (
    .i_pixclk(clk), .i_reset(rst),
    .i_hm_width(hw), .i_hm_porch(hp), .i_hm_synch(hs), .i_hm_raw(hr),
    .i_vm_height(vh), .i_vm_porch(vp), .i_vm_synch(vs), .i_vm_raw(vr),
    .o_rd(rd), .i_valid(valid), .i_word(word),
    .o_newframe(nf), .o_vga_hsync(hsync), .o_vga_vsync(vsync),
    .o_active(active), .o_pixel(pixel), .o_underflow(uflow)
  );

  typedef struct packed {
    logic           nf;
    logic           hs;
    logic           vs;
    logic           act;
    logic [BPP-1:0] pix;
    logic           uf;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   uf_cnt = 0;

  // Reference model: position is a linear index into the frame.
  int              t;
  int              m_w, m_hp, m_hs, m_hr, m_vh, m_vp, m_vs, m_vr;
  bit              lost;
  logic [BUSW-1:0] cur;
  logic [BUSW-1:0] head;
  bit              pattern;
  int              pat_idx;
  logic [BUSW-1:0] pat [2];

  function automatic logic [BUSW-1:0] next_word();
    if (pattern) return pat[pat_idx % 2];
    return BUSW'($urandom);
  endfunction

  task automatic latch_modes();
    m_w = hw; m_hp = hp; m_hs = hs; m_hr = hr;
    m_vh = vh; m_vp = vp; m_vs = vs; m_vr = vr;
  endtask

  task automatic step(input bit r, input bit starve);
    bit   a, nd, rd_e, nfe, ufe;
    int   h, v, k;
    obs_t e;
    @(negedge clk);
    rst   = r;
    valid = !starve;
    word  = head;
    #1;
    e = '0;
    rd_e = 1'b0;
    if (r) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      latch_modes();
      t = m_vh * m_hr;
      lost = 1'b0;
      cur = '0;
    end else begin
      h = t % m_hr;
      v = t / m_hr;
      k = h % PPW;
      a = (h < m_w) && (v < m_vh);
      nd = a && (k == 0);
      rd_e = nd && valid && !lost;
      ufe = nd && !valid && !lost;
      if (rd_e) cur = word;
      if (ufe) lost = 1'b1;
      nfe = (h == 0) && (v == m_vh);
      e.nf  = nfe;
      e.hs  = !(h >= m_hp && h < m_hs);
      e.vs  = !(v >= m_vp && v < m_vs);
      e.act = a;
      e.pix = (a && !lost) ? BPP'(cur >> (BUSW - BPP * (k + 1))) : '0;
      e.uf  = ufe;
      if (nfe) begin
        lost = 1'b0;
        pat_idx = 0;
        head = next_word();
      end
      if (t == m_hr * m_vr - 1) begin
        t = 0;
        latch_modes();
      end else begin
        t++;
      end
    end
    checks++;
    if (rd !== rd_e) begin
      errors++;
      $display("FAIL o_rd at %0t: got %b exp %b", $time, rd, rd_e);
    end
    if (rd_e) begin
      pat_idx++;
      head = next_word();
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!((t % m_hr) == h && (t / m_hr) == v) && n < 400) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_pos h=%0d v=%0d: not reached after %0d cycles", h, v, n);
    end
  endtask

  task automatic set_mode(input int w, input int p, input int s, input int r,
                          input int h, input int vpo, input int vsy, input int vra);
    hw = LW'(w); hp = LW'(p); hs = LW'(s); hr = LW'(r);
    vh = LW'(h); vp = LW'(vpo); vs = LW'(vsy); vr = LW'(vra);
  endtask

  obs_t ex, ac;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        ac = {nf, hsync, vsync, active, pixel, uflow};
        checks++;
        if (ac !== ex) begin
          errors++;
          $display("FAIL outputs at %0t: got nf%b hs%b vs%b act%b pix%h uf%b exp nf%b hs%b vs%b act%b pix%h uf%b",
                   $time, ac.nf, ac.hs, ac.vs, ac.act, ac.pix, ac.uf,
                   ex.nf, ex.hs, ex.vs, ex.act, ex.pix, ex.uf);
        end
        if (uflow === 1'b1) uf_cnt++;
      end
    end
  end

  initial begin
    int uf0, w, p, s, vht, vpo, vsy;
    pat[0] = 32'h0001_0203;
    pat[1] = 32'h0405_0607;
    pattern = 1'b1;
    pat_idx = 0;
    head = pat[0];
    set_mode(8, 10, 12, 14, 4, 5, 6, 7);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (300) step(1'b0, 1'b0);

    // narrow line mid-frame: takes effect at the next frame only
    hw = LW'(6);
    repeat (294) step(1'b0, 1'b0);
    hw = LW'(8);
    repeat (120) step(1'b0, 1'b0);

    // single missing word at line 2, pixel 4
    wait_pos(4, 2);
    uf0 = uf_cnt;
    step(1'b0, 1'b1);
    repeat (150) step(1'b0, 1'b0);
    checks++;
    if (uf_cnt - uf0 != 1) begin
      errors++;
      $display("FAIL underflow_count: got %0d exp 1", uf_cnt - uf0);
    end

    // reset in the middle of a visible line
    wait_pos(3, 1);
    step(1'b1, 1'b0);
    repeat (150) step(1'b0, 1'b0);

    // random words, modes, starvation and resets
    pattern = 1'b0;
    head = next_word();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        w   = $urandom_range(1, 12);
        p   = w + $urandom_range(1, 3);
        s   = p + $urandom_range(1, 3);
        vht = $urandom_range(1, 5);
        vpo = vht + $urandom_range(1, 2);
        vsy = vpo + $urandom_range(1, 2);
        set_mode(w, p, s, s + $urandom_range(0, 3), vht, vpo, vsy, vsy + $urandom_range(0, 2));
      end
      step($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 2);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
